branch_resolve_unit: RTL and testbench

- Consumes the signed Greater/Equal/Less flags from ALU_Comparator, plus an unsigned-less flag, and resolves RV32IM conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Sits directly downstream of the comparator in the execute stage.
- Computes the taken decision, the target and the next PC, and detects mispredictions against the fetch-stage prediction.
- Drives a pipeline flush with a programmable bubble window; valid/ready handshakes on both sides; results are registered.

---
 rtl/rv32im_pkg.sv | 20 ++
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/branch_cond_decode.sv | 29 ++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions for branch resolution: funct3 encodings, the
// resolve-unit state set and the sequential PC increment.
package rv32im_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } branch_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake and result bus between the execute-stage comparator side and the
// branch resolve unit; slave is the unit's view, master the surrounding pipe.
interface branch_resolve_unit_if #(
    parameter int data_width = 32,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            funct3;
    logic [data_width-1:0] pc;
    logic [data_width-1:0] imm;
    logic                  pred_taken;
    logic                  cmp_greater;
    logic                  cmp_equal;
    logic                  cmp_less;
    logic                  cmp_less_u;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_taken;
    logic [data_width-1:0] out_target;
    logic [data_width-1:0] out_next_pc;
    logic                  out_illegal;
    logic                  out_misaligned;
    logic                  flush;
    logic [data_width-1:0] flush_pc;
    logic [CNT_W-1:0]      mispredict_count;

    modport slave (
        input  in_valid, funct3, pc, imm, pred_taken,
               cmp_greater, cmp_equal, cmp_less, cmp_less_u, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_next_pc,
               out_illegal, out_misaligned, flush, flush_pc, mispredict_count
    );

    modport master (
        output in_valid, funct3, pc, imm, pred_taken,
               cmp_greater, cmp_equal, cmp_less, cmp_less_u, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_next_pc,
               out_illegal, out_misaligned, flush, flush_pc, mispredict_count
    );

endinterface

// File: rtl/branch_cond_decode.sv
// Combinational branch condition: maps funct3 and comparator flags to a taken
// decision, flagging the two non-branch funct3 codes as illegal.
module branch_cond_decode
    import rv32im_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       cmp_greater,
    input  logic       cmp_equal,
    input  logic       cmp_less,
    input  logic       cmp_less_u,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = cmp_equal;
            F3_BNE:  taken = !cmp_equal;
            F3_BLT:  taken = cmp_less;
            F3_BGE:  taken = cmp_greater | cmp_equal;
            F3_BLTU: taken = cmp_less_u;
            F3_BGEU: taken = !cmp_less_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: registers direction/target/next PC, detects
// mispredictions and holds off new branches for a flush bubble window.
module branch_resolve_unit
    import rv32im_pkg::*;
#(
    parameter int data_width   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    branch_state_e         state;
    branch_state_e         state_next;
    branch_state_e         accept_state;
    logic [FC_W-1:0]       flush_cnt;
    logic                  pending;
    logic                  taken;
    logic                  illegal;
    logic                  mispredict;
    logic                  accept;
    logic                  in_ready;
    logic                  out_valid;
    logic [data_width-1:0] target;
    logic [data_width-1:0] seq_pc;
    logic [data_width-1:0] next_pc;

    logic                  res_taken;
    logic                  res_illegal;
    logic                  res_misaligned;
    logic [data_width-1:0] res_target;
    logic [data_width-1:0] res_next_pc;
    logic                  flush_q;
    logic [data_width-1:0] flush_pc_q;
    logic [CNT_W-1:0]      count;

    branch_cond_decode u_decode (
        .funct3      (bus.funct3),
        .cmp_greater (bus.cmp_greater),
        .cmp_equal   (bus.cmp_equal),
        .cmp_less    (bus.cmp_less),
        .cmp_less_u  (bus.cmp_less_u),
        .taken       (taken),
        .illegal     (illegal)
    );

    assign target     = bus.pc + bus.imm;
    assign seq_pc     = bus.pc + data_width'(PC_INC);
    assign next_pc    = taken ? target : seq_pc;
    assign mispredict = (taken != bus.pred_taken) && !illegal;

    // With no bubble window a mispredicted result behaves like any other.
    assign accept_state = (mispredict && (FLUSH_CYCLES != 0)) ? FLUSH : HOLD;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_next = accept_state;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) state_next = bus.in_valid ? accept_state : IDLE;
            end
            FLUSH: begin
                out_valid = pending;
                if (flush_cnt == '0) state_next = (pending && !bus.out_ready) ? HOLD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_taken      <= 1'b0;
            res_illegal    <= 1'b0;
            res_misaligned <= 1'b0;
            res_target     <= '0;
            res_next_pc    <= '0;
            flush_cnt      <= '0;
            pending        <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            count          <= '0;
        end else begin
            flush_q <= accept && mispredict;
            if (accept) begin
                res_taken      <= taken;
                res_illegal    <= illegal;
                res_misaligned <= taken && (target[1:0] != 2'b00);
                res_target     <= target;
                res_next_pc    <= next_pc;
                flush_cnt      <= FC_LOAD;
                pending        <= 1'b1;
            end else begin
                if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FC_W'(1);
                if (out_valid && bus.out_ready) pending <= 1'b0;
            end
            if (accept && mispredict) begin
                flush_pc_q <= next_pc;
                if (count != '1) count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid;
    assign bus.out_taken        = res_taken;
    assign bus.out_target       = res_target;
    assign bus.out_next_pc      = res_next_pc;
    assign bus.out_illegal      = res_illegal;
    assign bus.out_misaligned   = res_misaligned;
    assign bus.flush            = flush_q;
    assign bus.flush_pc         = flush_pc_q;
    assign bus.mispredict_count = count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed plan scenarios plus
// randomized branches checked against a behavioural model of the rules.
module tb_branch_resolve_unit;
    import rv32im_pkg::*;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.data_width(32), .CNT_W(16)) bus ();
    branch_resolve_unit_if #(.data_width(32), .CNT_W(2))  sbus ();

    branch_resolve_unit #(.data_width(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    branch_resolve_unit #(.data_width(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    // Reference decision straight from the operand values.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                                  output logic tk, output logic il, output logic mp,
                                  output logic mis, output logic [31:0] npc);
        logic [31:0] tgt;
        tk = 1'b0;
        il = 1'b0;
        case (f3)
            3'b000:  tk = (a == b);
            3'b001:  tk = (a != b);
            3'b100:  tk = ($signed(a) < $signed(b));
            3'b101:  tk = ($signed(a) >= $signed(b));
            3'b110:  tk = (a < b);
            3'b111:  tk = (a >= b);
            default: il = 1'b1;
        endcase
        tgt = pc + imm;
        npc = tk ? tgt : pc + 32'd4;
        mis = tk && (tgt % 4 != 0);
        mp  = (tk != pred) && !il;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Upstream comparator emulation: flags derived from real operand values.
    task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        bus.funct3      = f3;
        bus.pc          = pc;
        bus.imm         = imm;
        bus.pred_taken  = pred;
        bus.cmp_greater = $signed(a) > $signed(b);
        bus.cmp_equal   = (a == b);
        bus.cmp_less    = $signed(a) < $signed(b);
        bus.cmp_less_u  = (a < b);
        bus.in_valid    = 1'b1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.funct3 = '0; bus.pc = '0; bus.imm = '0;
        bus.pred_taken = 1'b0; bus.cmp_greater = 1'b0; bus.cmp_equal = 1'b0;
        bus.cmp_less = 1'b0; bus.cmp_less_u = 1'b0;
        sbus.in_valid = 1'b0; sbus.out_ready = 1'b0; sbus.funct3 = '0; sbus.pc = '0; sbus.imm = '0;
        sbus.pred_taken = 1'b0; sbus.cmp_greater = 1'b0; sbus.cmp_equal = 1'b0;
        sbus.cmp_less = 1'b0; sbus.cmp_less_u = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_taken, bus.out_illegal, bus.out_misaligned, bus.flush} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100000", {bus.in_ready, bus.out_valid, bus.out_taken, bus.out_illegal, bus.out_misaligned, bus.flush});
        end
        n_checks++;
        if ({bus.out_target, bus.out_next_pc, bus.flush_pc, bus.mispredict_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: tgt=%h npc=%h fpc=%h cnt=%0d want all 0", bus.out_target, bus.out_next_pc, bus.flush_pc, bus.mispredict_count);
        end
        n_checks++;
        if ({sbus.in_ready, sbus.out_valid, sbus.mispredict_count} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_sat_unit: got %b want 1000", {sbus.in_ready, sbus.out_valid, sbus.mispredict_count});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_beq_hit();
        bus.out_ready = 1'b1;
        set_op(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_taken, bus.flush} !== 3'b110) begin
            n_fail++;
            $display("FAIL beq_flags: valid/taken/flush got %b want 110", {bus.out_valid, bus.out_taken, bus.flush});
        end
        n_checks++;
        if (bus.out_target !== 32'h120 || bus.out_next_pc !== 32'h120 || bus.mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL beq_result: tgt=%h npc=%h cnt=%0d want 120 120 0", bus.out_target, bus.out_next_pc, bus.mispredict_count);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_consumed: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_blt_mispredict();
        bus.out_ready = 1'b1;
        set_op(F3_BLT, -32'sd655, 32'd3, 32'h200, 32'hFFFF_FFF0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_taken, bus.flush, bus.in_ready} !== 4'b1110) begin
            n_fail++;
            $display("FAIL blt_flags: valid/taken/flush/in_ready got %b want 1110", {bus.out_valid, bus.out_taken, bus.flush, bus.in_ready});
        end
        n_checks++;
        if (bus.out_next_pc !== 32'h1F0 || bus.flush_pc !== 32'h1F0 || bus.mispredict_count !== 16'd1) begin
            n_fail++;
            $display("FAIL blt_result: npc=%h fpc=%h cnt=%0d want 1f0 1f0 1", bus.out_next_pc, bus.flush_pc, bus.mispredict_count);
        end
        step();
        n_checks++;
        if ({bus.flush, bus.in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL blt_window2: flush/in_ready got %b want 00", {bus.flush, bus.in_ready});
        end
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_window_end: in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_bgeu_wrap();
        bus.out_ready = 1'b1;
        set_op(F3_BGEU, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 1'b0);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_taken, bus.flush} !== 3'b100 || bus.out_next_pc !== 32'h0 || bus.out_target !== 32'h3C) begin
            n_fail++;
            $display("FAIL bgeu_wrap: flags=%b npc=%h tgt=%h want 100 0 3c", {bus.out_valid, bus.out_taken, bus.flush}, bus.out_next_pc, bus.out_target);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_op(F3_BNE, 32'd1, 32'd2, 32'h300, 32'h10, 1'b1);
        step();
        set_op(F3_BEQ, 32'd7, 32'd7, 32'h400, 32'h8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_taken} !== 3'b101 || bus.out_target !== 32'h310 || bus.out_next_pc !== 32'h310) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: flags=%b tgt=%h npc=%h want 101 310 310", i, {bus.out_valid, bus.in_ready, bus.out_taken}, bus.out_target, bus.out_next_pc);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: in_ready got %b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h408 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%b tgt=%h flush=%b want 1 408 0", bus.out_valid, bus.out_target, bus.flush);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_done: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_illegal_misaligned();
        bus.out_ready = 1'b1;
        set_op(3'b010, 32'd5, 32'd5, 32'h600, 32'h20, 1'b1);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_illegal, bus.out_taken, bus.flush} !== 4'b1100 || bus.out_next_pc !== 32'h604 || bus.mispredict_count !== 16'd1) begin
            n_fail++;
            $display("FAIL illegal: flags=%b npc=%h cnt=%0d want 1100 604 1", {bus.out_valid, bus.out_illegal, bus.out_taken, bus.flush}, bus.out_next_pc, bus.mispredict_count);
        end
        step();
        set_op(F3_BEQ, 32'd9, 32'd9, 32'h500, 32'h2, 1'b1);
        step();
        n_checks++;
        if ({bus.out_misaligned, bus.out_taken, bus.flush} !== 3'b110 || bus.out_target !== 32'h502) begin
            n_fail++;
            $display("FAIL misaligned_taken: flags=%b tgt=%h want 110 502", {bus.out_misaligned, bus.out_taken, bus.flush}, bus.out_target);
        end
        set_op(F3_BNE, 32'd9, 32'd9, 32'h500, 32'h2, 1'b0);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_misaligned, bus.out_taken} !== 2'b00 || bus.out_next_pc !== 32'h504) begin
            n_fail++;
            $display("FAIL misaligned_not_taken: flags=%b npc=%h want 00 504", {bus.out_misaligned, bus.out_taken}, bus.out_next_pc);
        end
        drain();
    endtask

    task automatic test_reset_mid_flush();
        bus.out_ready = 1'b1;
        set_op(F3_BNE, 32'd3, 32'd3, 32'h700, 32'h40, 1'b1);
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.flush, bus.in_ready} !== 2'b10 || bus.mispredict_count !== 16'd2) begin
            n_fail++;
            $display("FAIL pre_reset_flush: flush/in_ready=%b cnt=%0d want 10 2", {bus.flush, bus.in_ready}, bus.mispredict_count);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_taken, bus.flush} !== 4'b1000 || bus.out_next_pc !== '0 || bus.flush_pc !== '0 || bus.mispredict_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_flush: flags=%b npc=%h fpc=%h cnt=%0d want 1000 0 0 0", {bus.in_ready, bus.out_valid, bus.out_taken, bus.flush}, bus.out_next_pc, bus.flush_pc, bus.mispredict_count);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm, npc;
        logic        pred, tk, il, mp, mis;
        int          k, waited, exp_wait;
        int unsigned exp_count;
        exp_wait  = 0;
        exp_count = 0;
        for (int n = 0; n < 150; n++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 8)) - 32'd4;
            b    = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 8)) - 32'd4);
            pc   = $urandom();
            imm  = ($urandom_range(0, 1) == 0) ? $urandom() : (32'($urandom_range(0, 64)) - 32'd32);
            pred = 1'($urandom_range(0, 1));
            model(f3, a, b, pc, imm, pred, tk, il, mp, mis, npc);
            bus.out_ready = 1'b1;
            set_op(f3, a, b, pc, imm, pred);
            #1;
            waited = 0;
            while (bus.in_ready !== 1'b1 && waited < 10) begin
                step();
                waited++;
            end
            n_checks++;
            if (waited != exp_wait) begin
                n_fail++;
                $display("FAIL rnd_wait_%0d: in_ready low for %0d cycles want %0d", n, waited, exp_wait);
            end
            step();
            bus.in_valid = 1'b0;
            if (mp) exp_count++;
            k = $urandom_range(0, 2);
            bus.out_ready = (k == 0);
            n_checks++;
            if ({bus.out_valid, bus.out_taken, bus.out_illegal, bus.out_misaligned, bus.flush} !== {1'b1, tk, il, mis, mp}) begin
                n_fail++;
                $display("FAIL rnd_flags_%0d: v/tk/il/mis/fl got %b want %b (f3=%b a=%h b=%h)", n, {bus.out_valid, bus.out_taken, bus.out_illegal, bus.out_misaligned, bus.flush}, {1'b1, tk, il, mis, mp}, f3, a, b);
            end
            n_checks++;
            if (bus.out_target !== pc + imm || bus.out_next_pc !== npc || bus.mispredict_count !== 16'(exp_count) || (mp && bus.flush_pc !== npc)) begin
                n_fail++;
                $display("FAIL rnd_values_%0d: tgt=%h npc=%h fpc=%h cnt=%0d want %h %h %0d", n, bus.out_target, bus.out_next_pc, bus.flush_pc, bus.mispredict_count, pc + imm, npc, exp_count);
            end
            for (int j = 0; j < k; j++) begin
                step();
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.flush !== 1'b0 || bus.out_next_pc !== npc) begin
                    n_fail++;
                    $display("FAIL rnd_stall_%0d_%0d: valid=%b flush=%b npc=%h want 1 0 %h", n, j, bus.out_valid, bus.flush, bus.out_next_pc, npc);
                end
            end
            bus.out_ready = 1'b1;
            exp_wait = (mp && FC > k) ? FC - k : 0;
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [31:0] pcv;
        int unsigned exp;
        sbus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pcv = 32'h1000 + 32'(i) * 32'h10;
            sbus.funct3 = F3_BEQ; sbus.pc = pcv; sbus.imm = 32'h100; sbus.pred_taken = 1'b0;
            sbus.cmp_equal = 1'b1; sbus.cmp_greater = 1'b0; sbus.cmp_less = 1'b0; sbus.cmp_less_u = 1'b0;
            sbus.in_valid = 1'b1;
            #1;
            n_checks++;
            if (sbus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_in_ready_%0d: got %b want 1", i, sbus.in_ready);
            end
            step();
            exp = (i + 1 > 3) ? 3 : i + 1;
            n_checks++;
            if (sbus.mispredict_count !== 2'(exp) || sbus.flush !== 1'b1 || sbus.out_next_pc !== pcv + 32'h100) begin
                n_fail++;
                $display("FAIL sat_%0d: cnt=%0d flush=%b npc=%h want %0d 1 %h", i, sbus.mispredict_count, sbus.flush, sbus.out_next_pc, exp, pcv + 32'h100);
            end
        end
        sbus.in_valid = 1'b0;
        step();
        n_checks++;
        if ({sbus.out_valid, sbus.flush} !== 2'b00 || sbus.mispredict_count !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_final: valid/flush=%b cnt=%0d want 00 3", {sbus.out_valid, sbus.flush}, sbus.mispredict_count);
        end
    endtask

    initial begin
        test_reset();
        test_beq_hit();
        test_blt_mispredict();
        test_bgeu_wrap();
        test_backpressure();
        test_illegal_misaligned();
        test_reset_mid_flush();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
